// File: rtl/fb_access_arbiter.sv
// Frame-buffer access arbiter: one single-port 3-bit RAM shared between scan-out
// reads from the front bank and draw-engine writes to the back bank, with vblank bank swap.
module fb_access_arbiter #(
  parameter int WIN_X0   = 192,
  parameter int WIN_Y0   = 135,
  parameter int WIN_W    = 256,
  parameter int WIN_H    = 240,
  parameter int VBLANK_Y = 480
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        pix_en,
  input  logic [9:0]  counter_x,
  input  logic [8:0]  counter_y,
  input  logic [2:0]  ram_rdata,
  output logic [16:0] ram_addr,
  output logic        ram_we,
  output logic [2:0]  ram_wdata,
  output logic [2:0]  pix_rgb,
  input  logic        wr_req,
  input  logic [15:0] wr_addr,
  input  logic [2:0]  wr_data,
  output logic        wr_ack,
  input  logic        frame_done,
  output logic        swap_pending,
  output logic        front_bank
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;

  localparam logic [9:0] X_LO = 10'(WIN_X0);
  localparam logic [9:0] X_HI = 10'(WIN_X0 + WIN_W);
  localparam logic [8:0] Y_LO = 9'(WIN_Y0);
  localparam logic [8:0] Y_HI = 9'(WIN_Y0 + WIN_H);
  localparam logic [8:0] Y_VB = 9'(VBLANK_Y);

  logic [0:0]  state_q, state_d;
  logic        front_bank_q, front_bank_d;
  logic [16:0] ram_addr_q, ram_addr_d;
  logic        ram_we_q, ram_we_d;
  logic [2:0]  ram_wdata_q, ram_wdata_d;
  logic        wr_ack_q, wr_ack_d;
  logic [2:0]  pix_rgb_q, pix_rgb_d;
  logic        pixValid1_q, pixValid2_q;
  logic        inWin1_q, inWin2_q;

  logic        inWindow;
  logic        readSlot;
  logic        vblankStart;
  logic        grant;
  logic [7:0]  xOff;
  logic [7:0]  yOff;

  assign inWindow    = (counter_x >= X_LO) && (counter_x < X_HI) &&
                       (counter_y >= Y_LO) && (counter_y < Y_HI);
  assign readSlot    = pix_en && inWindow;
  assign vblankStart = pix_en && (counter_x == 10'd0) && (counter_y == Y_VB);
  // Offsets are only meaningful inside the window, so 8-bit wrapping math is enough.
  assign xOff        = counter_x[7:0] - X_LO[7:0];
  assign yOff        = counter_y[7:0] - Y_LO[7:0];
  assign grant       = wr_req && (state_q == ST_RUN) && !readSlot && !wr_ack_q && !ram_we_q;

  always_comb begin
    state_d      = state_q;
    front_bank_d = front_bank_q;
    ram_addr_d   = ram_addr_q;
    ram_we_d     = 1'b0;
    ram_wdata_d  = ram_wdata_q;
    wr_ack_d     = 1'b0;
    pix_rgb_d    = pix_rgb_q;

    if (readSlot) begin
      ram_addr_d = {front_bank_q, yOff, xOff};
    end else if (grant) begin
      ram_addr_d  = {~front_bank_q, wr_addr};
      ram_we_d    = 1'b1;
      ram_wdata_d = wr_data;
      wr_ack_d    = 1'b1;
    end

    // RAM data for a read slot lands two cycles after the pixel strobe.
    if (pixValid2_q) begin
      pix_rgb_d = inWin2_q ? ram_rdata : 3'b000;
    end

    case (state_q)
      ST_RUN: begin
        if (frame_done) state_d = ST_PEND;
      end
      ST_PEND: begin
        if (vblankStart) begin
          state_d      = ST_RUN;
          front_bank_d = ~front_bank_q;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_RUN;
      front_bank_q <= 1'b0;
      ram_addr_q   <= '0;
      ram_we_q     <= 1'b0;
      ram_wdata_q  <= '0;
      wr_ack_q     <= 1'b0;
      pix_rgb_q    <= '0;
      pixValid1_q  <= 1'b0;
      pixValid2_q  <= 1'b0;
      inWin1_q     <= 1'b0;
      inWin2_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      front_bank_q <= front_bank_d;
      ram_addr_q   <= ram_addr_d;
      ram_we_q     <= ram_we_d;
      ram_wdata_q  <= ram_wdata_d;
      wr_ack_q     <= wr_ack_d;
      pix_rgb_q    <= pix_rgb_d;
      pixValid1_q  <= pix_en;
      pixValid2_q  <= pixValid1_q;
      inWin1_q     <= inWindow;
      inWin2_q     <= inWin1_q;
    end
  end

  assign ram_addr     = ram_addr_q;
  assign ram_we       = ram_we_q;
  assign ram_wdata    = ram_wdata_q;
  assign wr_ack       = wr_ack_q;
  assign pix_rgb      = pix_rgb_q;
  assign swap_pending = (state_q == ST_PEND);
  assign front_bank   = front_bank_q;

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Scoreboard bench for fb_access_arbiter: drivers push expected pixels/addresses/writes,
// negedge monitors pop and compare whenever the DUT presents a result.
module tb_fb_access_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        pix_en;
  logic [9:0]  counter_x;
  logic [8:0]  counter_y;
  logic [2:0]  ram_rdata;
  logic [16:0] ram_addr;
  logic        ram_we;
  logic [2:0]  ram_wdata;
  logic [2:0]  pix_rgb;
  logic        wr_req;
  logic [15:0] wr_addr;
  logic [2:0]  wr_data;
  logic        wr_ack;
  logic        frame_done;
  logic        swap_pending;
  logic        front_bank;

  always #5 clock = ~clock;

  fb_access_arbiter dut (
    .clock(clock), .reset_n(reset_n), .pix_en(pix_en),
    .counter_x(counter_x), .counter_y(counter_y), .ram_rdata(ram_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .pix_rgb(pix_rgb),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .frame_done(frame_done), .swap_pending(swap_pending), .front_bank(front_bank)
  );

  logic [2:0] ramMem  [0:131071];
  logic [2:0] goldMem [0:131071];

  // Synchronous single-port RAM with one cycle read latency
  always @(posedge clock) begin
    if (ram_we) ramMem[ram_addr] <= ram_wdata;
    ram_rdata <= ramMem[ram_addr];
  end

  int vecCount = 0;
  int missCount = 0;
  int ackCount = 0;
  int ackBase;
  int waited;
  int wrIdx;
  int wrWaited;
  bit stopWriter;
  bit checkEn = 1'b0;
  bit fbModel = 1'b0;
  bit pendModel = 1'b0;
  logic prevAck = 1'b0;

  logic [2:0]  pixQ[$];
  logic [16:0] addrQ[$];
  logic [19:0] wrQ[$];

  function automatic bit inWin(input int x, input int y);
    return (x >= 192) && (x < 448) && (y >= 135) && (y < 375);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives one pixel (strobe cycle plus idle cycle) and records what the DUT owes for it
  task automatic applyStimulus(input int x, input int y, input bit fd);
    logic [16:0] a;
    pix_en = 1'b1;
    counter_x = 10'(x);
    counter_y = 9'(y);
    frame_done = fd;
    if (inWin(x, y)) begin
      a = {fbModel, 8'(y - 135), 8'(x - 192)};
      addrQ.push_back(a);
      pixQ.push_back(goldMem[a]);
    end else begin
      pixQ.push_back(3'b000);
    end
    if (pendModel && x == 0 && y == 480) begin
      fbModel = ~fbModel;
      pendModel = 1'b0;
    end else if (!pendModel && fd) begin
      pendModel = 1'b1;
    end
    @(negedge clock);
    pix_en = 1'b0;
    frame_done = 1'b0;
    @(negedge clock);
  endtask

  task automatic writeReq(input logic [15:0] a, input logic [2:0] d, input int maxCycles, output int w);
    logic bank;
    bank = pendModel ? fbModel : ~fbModel;
    wr_req = 1'b1;
    wr_addr = a;
    wr_data = d;
    wrQ.push_back({bank, a, d});
    w = 0;
    do begin
      @(negedge clock);
      w++;
    end while (!wr_ack && w < maxCycles);
    checkOutput("writeTimeout", 32'(wr_ack), 32'd1);
    wr_req = 1'b0;
  endtask

  logic s1 = 1'b0, s2 = 1'b0, s3 = 1'b0, w1 = 1'b0;
  always @(posedge clock) begin
    s1 <= pix_en;
    s2 <= s1;
    s3 <= s2;
    w1 <= pix_en && inWin(int'(counter_x), int'(counter_y));
  end

  // Monitor: pixel results, read addresses and write issues, each against its queue
  always @(negedge clock) begin
    logic [19:0] e;
    if (checkEn) begin
      if (s3) begin
        checkOutput("pixQueueNonEmpty", 32'(pixQ.size() != 0), 32'd1);
        if (pixQ.size() != 0) checkOutput("pixRgb", 32'(pix_rgb), 32'(pixQ.pop_front()));
      end
      if (w1) begin
        checkOutput("addrQueueNonEmpty", 32'(addrQ.size() != 0), 32'd1);
        if (addrQ.size() != 0) checkOutput("readAddr", 32'(ram_addr), 32'(addrQ.pop_front()));
        checkOutput("readWe", 32'(ram_we), 32'd0);
      end
      if (wr_ack) begin
        ackCount++;
        checkOutput("ackSpacing", 32'(prevAck), 32'd0);
        checkOutput("writeWe", 32'(ram_we), 32'd1);
        checkOutput("wrQueueNonEmpty", 32'(wrQ.size() != 0), 32'd1);
        if (wrQ.size() != 0) begin
          e = wrQ.pop_front();
          checkOutput("writeAddr", 32'(ram_addr), 32'(e[19:3]));
          checkOutput("writeData", 32'(ram_wdata), 32'(e[2:0]));
          goldMem[e[19:3]] = e[2:0];
        end
      end
      prevAck = wr_ack;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    pix_en = 1'b0;
    counter_x = '0;
    counter_y = '0;
    wr_req = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    frame_done = 1'b0;
    for (int i = 0; i < 131072; i++) begin
      goldMem[i] = 3'(i) ^ 3'(i >> 8);
      ramMem[i]  = 3'(i) ^ 3'(i >> 8);
    end
    goldMem[17'h00000] = 3'b101; ramMem[17'h00000] = 3'b101;
    goldMem[17'h0EFFF] = 3'b011; ramMem[17'h0EFFF] = 3'b011;
    goldMem[17'h10000] = 3'b010; ramMem[17'h10000] = 3'b010;
    goldMem[17'h1EFFF] = 3'b110; ramMem[17'h1EFFF] = 3'b110;

    repeat (3) @(negedge clock);
    checkOutput("resetAddr", 32'(ram_addr), 32'd0);
    checkOutput("resetFront", 32'(front_bank), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // Reset arriving while a write is on the RAM port
    wr_req = 1'b1;
    wr_addr = 16'h0042;
    wr_data = 3'b111;
    @(posedge clock);
    #2;
    checkOutput("ackBeforeReset", 32'(wr_ack), 32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("asyncRamAddr", 32'(ram_addr), 32'd0);
    checkOutput("asyncRamWe", 32'(ram_we), 32'd0);
    checkOutput("asyncRamWdata", 32'(ram_wdata), 32'd0);
    checkOutput("asyncPixRgb", 32'(pix_rgb), 32'd0);
    checkOutput("asyncWrAck", 32'(wr_ack), 32'd0);
    checkOutput("asyncSwapPending", 32'(swap_pending), 32'd0);
    checkOutput("asyncFrontBank", 32'(front_bank), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    checkEn = 1'b1;
    ackBase = ackCount;
    writeReq(16'h0042, 3'b111, 20, waited);
    checkOutput("resetReqLatency", 32'(waited), 32'd1);
    repeat (4) @(negedge clock);
    checkOutput("resetAckOnce", 32'(ackCount - ackBase), 32'd1);

    // Window corners and just outside
    applyStimulus(192, 135, 1'b0);
    applyStimulus(447, 374, 1'b0);
    applyStimulus(191, 135, 1'b0);

    // Write request colliding with an in-window read
    fork
      writeReq(16'h1234, 3'b110, 20, waited);
      applyStimulus(200, 140, 1'b0);
    join
    checkOutput("contentionLatency", 32'(waited), 32'd2);

    // Continuous writer against full scan lines
    stopWriter = 1'b0;
    wrIdx = 0;
    fork
      begin
        while (!stopWriter) begin
          writeReq(16'h2000 + 16'(wrIdx), 3'(wrIdx), 20, wrWaited);
          wrIdx++;
        end
      end
      begin
        for (int y = 134; y <= 136; y++) begin
          if (y == 134) ackBase = ackCount;
          for (int x = 0; x < 640; x++) applyStimulus(x, y, 1'b0);
          if (y == 134) checkOutput("outOfWindowBandwidth", 32'((ackCount - ackBase) >= 636), 32'd1);
        end
        stopWriter = 1'b1;
      end
    join
    repeat (4) @(negedge clock);

    // Frame done mid-frame, writes held off until the vblank swap
    applyStimulus(0, 300, 1'b1);
    checkOutput("swapPendingSet", 32'(swap_pending), 32'd1);
    checkOutput("frontBeforeSwap", 32'(front_bank), 32'd0);
    fork
      writeReq(16'h0333, 3'b001, 100, waited);
      begin
        ackBase = ackCount;
        applyStimulus(10, 300, 1'b0);
        applyStimulus(20, 301, 1'b0);
        applyStimulus(30, 302, 1'b0);
        checkOutput("ackBlockedWhilePending", 32'(ackCount - ackBase), 32'd0);
        applyStimulus(0, 480, 1'b0);
        checkOutput("frontAfterSwap", 32'(front_bank), 32'd1);
        checkOutput("swapPendingClear", 32'(swap_pending), 32'd0);
      end
    join
    applyStimulus(192, 135, 1'b0);
    applyStimulus(447, 374, 1'b0);

    // Frame done on the vblank-start strobe defers the swap by a frame
    applyStimulus(0, 480, 1'b1);
    checkOutput("coincidentNoSwap", 32'(front_bank), 32'd1);
    checkOutput("coincidentPending", 32'(swap_pending), 32'd1);
    applyStimulus(0, 300, 1'b1);
    checkOutput("secondDoneFront", 32'(front_bank), 32'd1);
    checkOutput("secondDonePending", 32'(swap_pending), 32'd1);
    applyStimulus(0, 480, 1'b0);
    checkOutput("deferredSwapFront", 32'(front_bank), 32'd0);
    checkOutput("deferredSwapPending", 32'(swap_pending), 32'd0);
    applyStimulus(192, 135, 1'b0);

    repeat (6) @(negedge clock);
    checkOutput("pixQueueDrained", 32'(pixQ.size()), 32'd0);
    checkOutput("addrQueueDrained", 32'(addrQ.size()), 32'd0);
    checkOutput("wrQueueDrained", 32'(wrQ.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/fb_access_arbiter.md
Name: fb_access_arbiter

Overview:
- Arbitrates one synchronous single-port 3-bit frame-buffer RAM between VGA scan-out (reader) and the draw engine (writer).
- Double-buffered: scan-out reads the front bank while the draw engine writes the back bank.
- Banks swap only at vertical-blank start, after the draw engine signals frame completion.
- Sits between hvsync_generator/draw and the RAM; its pix_rgb output feeds the R/G/B output registers.

Parameters:
- WIN_X0, 192, first active window column.
- WIN_Y0, 135, first active window row.
- WIN_W, 256, window width in pixels; a power of 2.
- WIN_H, 240, window height in rows.
- VBLANK_Y, 480, row at which vertical blank starts.

Ports:
- clock  in  1  system clock, 2x the pixel clock.
- reset_n  in  1  asynchronous active-low reset.
- pix_en  in  1  one-cycle pulse per pixel; CounterX/CounterY are valid on that cycle.
- counter_x  in  10  current pixel column.
- counter_y  in  9  current pixel row.
- ram_rdata  in  3  RAM read data, 1-cycle synchronous read latency.
- ram_addr  out  17  RAM address; bit 16 selects the bank.
- ram_we  out  1  RAM write enable.
- ram_wdata  out  3  RAM write data.
- pix_rgb  out  3  pixel colour {B,G,R} for scan-out.
- wr_req  in  1  writer request; hold with wr_addr/wr_data stable until wr_ack.
- wr_addr  in  16  back-bank address {row[7:0],col[7:0]}.
- wr_data  in  3  write colour.
- wr_ack  out  1  one-cycle pulse: the write has been issued to the RAM.
- frame_done  in  1  one-cycle pulse: the back bank is complete.
- swap_pending  out  1  high from frame_done until the bank swap.
- front_bank  out  1  bank currently scanned out.

Behaviour:
- Reset (asynchronous, reset_n=0): ram_addr=0, ram_we=0, ram_wdata=0, pix_rgb=0, wr_ack=0, swap_pending=0, front_bank=0, swap FSM=RUN. Any in-flight write is dropped; the writer re-requests.
- All outputs are registered.
- In-window test: WIN_X0 <= x < WIN_X0+WIN_W and WIN_Y0 <= y < WIN_Y0+WIN_H.

Read slot:
- Occurs on cycle N when pix_en=1 and (counter_x,counter_y) is in-window.
- Cycle N+1: ram_addr={front_bank, (y-WIN_Y0)[7:0], (x-WIN_X0)[7:0]}, ram_we=0.
- Cycle N+2: pix_rgb<=ram_rdata.
- pix_en=1 out of window: pix_rgb<=0 at N+2, with no RAM access.
- pix_rgb holds its value between updates.

Write grant:
- Granted on cycle N when wr_req=1 and swap FSM=RUN, and none of the following hold:
  - cycle N is a read slot;
  - wr_ack=1 on cycle N (no back-to-back grants);
  - a write was already issued at N.
- Cycle N+1: ram_addr={~front_bank, wr_addr}, ram_we=1, ram_wdata=wr_data, wr_ack=1.
- ram_we=0 on every non-write cycle.
- Read always beats write. With pix_en at half rate, the writer gets at least one slot per two pixels out of window and one per four cycles worst case.

Swap FSM:
- RUN: frame_done=1 -> PEND, swap_pending<=1.
- PEND: writes blocked (wr_ack stays 0); further frame_done ignored.
- PEND and (pix_en && counter_x==0 && counter_y==VBLANK_Y): front_bank<=~front_bank, swap_pending<=0 -> RUN.
- frame_done in RUN on the same cycle as the vblank-start condition: enter PEND; the swap waits for the next frame's vblank start.
- A grant issued on the frame_done cycle still completes.

Widths: the subtraction results are truncated to 8 bits, valid only inside the window. No wrap outside the window, because no read is issued there.

Test Plan:
- Reset: hold reset_n=0 mid-write (wr_req=1) -> all outputs 0 and front_bank=0 asynchronously; after release, wr_ack pulses exactly once for the held request.
- Read path: preload bank0 addr 0x0000=3'b101, addr 0xEFFF=3'b011; pix_en at (192,135) -> ram_addr=0x00000, pix_rgb=101 two cycles later. Pixel (447,374) -> ram_addr=0x0EFFF, pix_rgb=011. Pixel (191,135) -> no access, pix_rgb=000.
- Contention: wr_req=1, wr_addr=0x1234, data=110, on a cycle with an in-window pix_en -> read issued first; write appears the next cycle at ram_addr=0x11234, ram_we=1, wr_ack=1; wr_ack pulses are never on consecutive cycles.
- Bandwidth: continuous wr_req over one full 640x480 frame -> no read slot is missed (pix_rgb matches the golden model for every pixel), and write count >= 4 per 8 cycles outside the window.
- Swap: frame_done at line 300 -> swap_pending=1, wr_ack held 0 despite wr_req. At pix_en with (0,480): front_bank 0->1, swap_pending=0. The next frame reads use bit16=1; writes go to bit16=0.
- Coincident: frame_done on the same cycle as vblank start -> no swap this frame; swap at the next (0,480); a second frame_done while PEND changes nothing.
